can_tx_bitstuffer: RTL and testbench
====================================

Name: can_tx_bitstuffer

Overview:
- Transmit-side counterpart of the receive sample buffer and destuffer path in the CAN core.
- Takes the serial frame bit stream from the TX shift logic one bit per bit time.
- Inserts a complementary stuff bit after STUFF_LEN consecutive equal bits while stuffing is enabled.
- Drives the registered CAN TX line.
- Advances only on bit-time ticks qualified by the prescaler enable.

Parameters:
- STUFF_LEN, 5: number of equal consecutive bits that triggers one stuff bit.
- CNT_W, 3: width of the equal-bit run counter; must hold STUFF_LEN.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- Prescale_EN  input  1  prescaler enable; nothing advances when low
- bit_tick  input  1  transmit point of the bit time; acted on only when Prescale_EN=1
- stuff_en  input  1  stuffing region active (SOF through CRC sequence)
- data_in  input  1  next frame bit from upstream
- data_valid  input  1  data_in is valid
- data_ready  output  1  combinational; bit consumed this clock when data_ready && data_valid
- tx  output  1  registered CAN TX line; 1 = recessive
- stuff_sent  output  1  one-clock pulse when a stuff bit is driven onto tx
- underrun  output  1  sticky; a tick found no valid data while busy
- run_cnt  output  CNT_W  current equal-bit run length, for debug

Behaviour:
- Reset values: tx=1, stuff_sent=0, underrun=0, run_cnt=0, last_bit=1, state=IDLE. Reset is asynchronous, active-high, and may occur at any time. It aborts any pending stuff bit immediately.
- tick = Prescale_EN && bit_tick. All state changes except reset occur at a posedge clock with tick=1.
- States: IDLE, DATA, STUFF.
- IDLE:
  - tx holds 1.
  - data_ready = tick.
  - On consume: tx<=data_in, go to DATA.
  - No consume: remain in IDLE, underrun stays 0.
- DATA:
  - data_ready = tick && !stuff_pending.
  - On consume: tx<=data_in (latency exactly one clock from the consuming edge).
  - On a tick with no valid data: tx<=1, underrun<=1, go to IDLE, run_cnt<=0.
- Run counting:
  - Done on each data bit driven while stuff_en=1.
  - If data_in==last_bit: run_cnt<=run_cnt+1. Otherwise run_cnt<=1. In both cases last_bit<=data_in.
  - When run_cnt reaches STUFF_LEN: set stuff_pending and go to STUFF after this bit.
- stuff_en is sampled with each consumed data bit.
  - A bit consumed with stuff_en=0 drives tx, clears run_cnt to 0, and sets last_bit=data_in.
  - A run completed by the last bit consumed with stuff_en=1 still produces its stuff bit, even if stuff_en falls on the next tick (CRC-end rule).
- STUFF:
  - data_ready=0.
  - On next tick: tx<=~last_bit, stuff_sent pulses for one clock, run_cnt<=1, last_bit<=~last_bit.
  - Then return to DATA. The stuff bit counts as the first bit of the next run.
- Simultaneous events:
  - stuff_en falling on the same tick as a stuff bit: the stuff bit is still sent.
  - data_valid high during STUFF: the bit is held upstream, not lost.
- No tick means tx and all state are held, regardless of data_valid.
- run_cnt never exceeds STUFF_LEN.
- underrun clears only by reset.

Optional Feature:
- Macro: CAN_TX_STUFF_ERR_INJ_EN.
- Defined:
  - Adds input port inject_stuff_err.
  - If it is 1 on the tick that sends a stuff bit, tx<=last_bit (wrong polarity) instead of ~last_bit. stuff_sent still pulses.
  - run_cnt then becomes STUFF_LEN+1 saturated at STUFF_LEN, and no further stuff bit is inserted until the run breaks.
  - Used to force stuff errors at the far-end receiver.
- Undefined: port absent, stuff bits always complementary.

Test Plan:
- Stream 0,0,0,0,0,1 with stuff_en=1, tick every 4 clocks -> tx shows 0,0,0,0,0,1(stuff),1. stuff_sent pulses once. data_ready=0 during the stuff tick.
- Stream of ten 1s with stuff_en=1 -> tx shows 11111 0 11111 0. Two stuff_sent pulses. run_cnt returns to 1 after each stuff bit.
- Five 0s with stuff_en falling on the tick after the 5th bit -> stuff bit 1 still sent. Following bits 0,0,0,0,0,0 with stuff_en=0 produce no stuff bit.
- Prescale_EN=0 with bit_tick pulsing and data_valid=1 -> tx and run_cnt unchanged, no consumption.
- In DATA, drop data_valid at a tick -> tx=1, underrun=1 stays set, state IDLE. Assert reset mid-STUFF -> tx=1 asynchronously and no stuff bit is emitted after release.
- With CAN_TX_STUFF_ERR_INJ_EN: five 1s plus inject_stuff_err=1 -> sixth tx bit is 1 and stuff_sent pulses.

Source files
------------

// File: rtl/can_tx_bitstuffer.sv
// can_tx_bitstuffer
// Transmit-side bit stuffer for the CAN core. It takes one frame bit per bit
// time from the TX shift logic and drives the registered CAN TX line. While
// stuff_en is high, a complementary stuff bit is inserted after STUFF_LEN
// consecutive equal bits. Everything advances only on a bit tick qualified by
// Prescale_EN.
//
// Optional build macro: CAN_TX_STUFF_ERR_INJ_EN
//   When defined, adds input inject_stuff_err. A stuff bit sent while this
//   input is high is driven with the wrong polarity, which forces a stuff
//   error at the far-end receiver.
module can_tx_bitstuffer #(
    parameter int STUFF_LEN = 5,
    parameter int CNT_W     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Prescale_EN,
    input  logic             bit_tick,
    input  logic             stuff_en,
    input  logic             data_in,
    input  logic             data_valid,
`ifdef CAN_TX_STUFF_ERR_INJ_EN
    input  logic             inject_stuff_err,
`endif
    output logic             data_ready,
    output logic             tx,
    output logic             stuff_sent,
    output logic             underrun,
    output logic [CNT_W-1:0] run_cnt
);

    localparam logic [CNT_W-1:0] STUFF_LEN_C = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W:0]   STUFF_LEN_W = (CNT_W + 1)'(STUFF_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STUFF = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             tx_r;
    logic             tx_nxt_s;
    logic             stuff_sent_r;
    logic             stuff_sent_nxt_s;
    logic             underrun_r;
    logic             underrun_nxt_s;
    logic [CNT_W-1:0] run_cnt_r;
    logic [CNT_W-1:0] run_cnt_nxt_s;
    logic             last_bit_r;
    logic             last_bit_nxt_s;

    logic             tick_s;
    logic             consume_s;
    logic             stuff_pending_s;
    logic             inject_s;
    logic             same_bit_s;
    logic [CNT_W:0]   cnt_inc_s;
    logic [CNT_W-1:0] run_next_s;
    logic             run_hit_s;

    assign tick_s          = Prescale_EN && bit_tick;
    assign consume_s       = data_ready && data_valid;
    assign stuff_pending_s = (state_r == ST_STUFF);

`ifdef CAN_TX_STUFF_ERR_INJ_EN
    assign inject_s = inject_stuff_err;
`else
    assign inject_s = 1'b0;
`endif

    // Run length after the incoming bit: extend or restart, saturating at STUFF_LEN.
    assign same_bit_s = (data_in == last_bit_r);
    assign cnt_inc_s  = {1'b0, run_cnt_r} + {{CNT_W{1'b0}}, 1'b1};

    // Next run count for a stuffed data bit, never above STUFF_LEN.
    always_comb begin
        run_next_s = CNT_ONE_C;
        if (same_bit_s) begin
            if (cnt_inc_s >= STUFF_LEN_W) begin
                run_next_s = STUFF_LEN_C;
            end else begin
                run_next_s = cnt_inc_s[CNT_W-1:0];
            end
        end else begin
            run_next_s = CNT_ONE_C;
        end
    end

    // A stuff bit is owed only when the run newly reaches STUFF_LEN; a run
    // already saturated (after an injected error) must break first.
    assign run_hit_s = stuff_en && (run_next_s == STUFF_LEN_C) &&
                       ((run_cnt_r != STUFF_LEN_C) || !same_bit_s);

    // Upstream handshake: ready only on a tick and never while a stuff bit is owed.
    always_comb begin
        data_ready = 1'b0;
        case (state_r)
            ST_IDLE:  data_ready = tick_s;
            ST_DATA:  data_ready = tick_s && !stuff_pending_s;
            ST_STUFF: data_ready = 1'b0;
            default:  data_ready = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: consume moves to DATA or STUFF, a starved tick drops to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (consume_s) begin
                    state_nxt_s = run_hit_s ? ST_STUFF : ST_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (consume_s) begin
                    state_nxt_s = run_hit_s ? ST_STUFF : ST_DATA;
                end else if (tick_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STUFF: begin
                if (tick_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_STUFF;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the TX line, run tracking and status flags.
    always_comb begin
        tx_nxt_s         = tx_r;
        run_cnt_nxt_s    = run_cnt_r;
        last_bit_nxt_s   = last_bit_r;
        stuff_sent_nxt_s = 1'b0;
        underrun_nxt_s   = underrun_r;
        case (state_r)
            ST_IDLE, ST_DATA: begin
                if (consume_s) begin
                    tx_nxt_s       = data_in;
                    last_bit_nxt_s = data_in;
                    if (stuff_en) begin
                        run_cnt_nxt_s = run_next_s;
                    end else begin
                        run_cnt_nxt_s = CNT_ZERO_C;
                    end
                end else if (tick_s && (state_r == ST_DATA)) begin
                    tx_nxt_s       = 1'b1;
                    underrun_nxt_s = 1'b1;
                    run_cnt_nxt_s  = CNT_ZERO_C;
                end else begin
                    tx_nxt_s = tx_r;
                end
            end
            ST_STUFF: begin
                if (tick_s) begin
                    stuff_sent_nxt_s = 1'b1;
                    if (inject_s) begin
                        tx_nxt_s      = last_bit_r;
                        run_cnt_nxt_s = STUFF_LEN_C;
                    end else begin
                        tx_nxt_s       = ~last_bit_r;
                        last_bit_nxt_s = ~last_bit_r;
                        run_cnt_nxt_s  = CNT_ONE_C;
                    end
                end else begin
                    tx_nxt_s = tx_r;
                end
            end
            default: begin
                tx_nxt_s      = 1'b1;
                run_cnt_nxt_s = CNT_ZERO_C;
            end
        endcase
    end

    // Datapath registers; reset drives the line recessive and drops any owed stuff bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_r         <= 1'b1;
            stuff_sent_r <= 1'b0;
            underrun_r   <= 1'b0;
            run_cnt_r    <= CNT_ZERO_C;
            last_bit_r   <= 1'b1;
        end else begin
            tx_r         <= tx_nxt_s;
            stuff_sent_r <= stuff_sent_nxt_s;
            underrun_r   <= underrun_nxt_s;
            run_cnt_r    <= run_cnt_nxt_s;
            last_bit_r   <= last_bit_nxt_s;
        end
    end

    assign tx         = tx_r;
    assign stuff_sent = stuff_sent_r;
    assign underrun   = underrun_r;
    assign run_cnt    = run_cnt_r;

endmodule

// File: tb/tb_can_tx_bitstuffer.sv
// Testbench for can_tx_bitstuffer. Each bit time pushes the expected TX
// line, stuff pulse and run count into a scoreboard queue; the entry is
// popped and compared after the clock edge that acts on the tick.
module tb_can_tx_bitstuffer;

    logic       clock;
    logic       reset;
    logic       Prescale_EN;
    logic       bit_tick;
    logic       stuff_en;
    logic       data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       stuff_sent;
    logic       underrun;
    logic [2:0] run_cnt;
`ifdef CAN_TX_STUFF_ERR_INJ_EN
    logic       inject_stuff_err;
`endif

    typedef struct packed {
        logic       tx;
        logic       ss;
        logic [2:0] rc;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks;
    int    n_errors;
    string cur_test;

    can_tx_bitstuffer #(.STUFF_LEN(5), .CNT_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .Prescale_EN (Prescale_EN),
        .bit_tick    (bit_tick),
        .stuff_en    (stuff_en),
        .data_in     (data_in),
        .data_valid  (data_valid),
`ifdef CAN_TX_STUFF_ERR_INJ_EN
        .inject_stuff_err (inject_stuff_err),
`endif
        .data_ready  (data_ready),
        .tx          (tx),
        .stuff_sent  (stuff_sent),
        .underrun    (underrun),
        .run_cnt     (run_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s/%s: observed %0h expected %0h", cur_test, tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        bit_tick    = 1'b0;
        Prescale_EN = 1'b1;
        data_valid  = 1'b0;
        #1;
        check_val("rst_tx", 8'(tx), 8'd1);
        check_val("rst_ss", 8'(stuff_sent), 8'd0);
        check_val("rst_ur", 8'(underrun), 8'd0);
        check_val("rst_rc", 8'(run_cnt), 8'd0);
        sb_q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One bit time (4 clocks): tick for one clock, then three idle clocks.
    task automatic bit_time(input logic pe, input logic v, input logic d, input logic se,
                            input logic e_rdy, input logic e_tx, input logic e_ss,
                            input logic [2:0] e_rc);
        exp_t e;
        @(negedge clock);
        Prescale_EN = pe;
        bit_tick    = 1'b1;
        data_valid  = v;
        data_in     = d;
        stuff_en    = se;
        #1;
        check_val("ready", 8'(data_ready), 8'(e_rdy));
        sb_q.push_back('{tx: e_tx, ss: e_ss, rc: e_rc});
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("tx", 8'(tx), 8'(e.tx));
            check_val("stuff_sent", 8'(stuff_sent), 8'(e.ss));
            check_val("run_cnt", 8'(run_cnt), 8'(e.rc));
            @(negedge clock);
            bit_tick    = 1'b0;
            Prescale_EN = 1'b1;
            @(posedge clock);
            #1;
            check_val("ss_pulse", 8'(stuff_sent), 8'd0);
            check_val("tx_hold", 8'(tx), 8'(e.tx));
        end
        repeat (2) @(posedge clock);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        Prescale_EN = 1'b0;
        bit_tick    = 1'b0;
        stuff_en    = 1'b0;
        data_in     = 1'b0;
        data_valid  = 1'b0;
`ifdef CAN_TX_STUFF_ERR_INJ_EN
        inject_stuff_err = 1'b0;
`endif
        cur_test = "reset";
        do_reset();

        // 0,0,0,0,0 -> stuff 1 -> 1, with gated ticks in the middle.
        cur_test = "zeros";
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        cur_test = "gated";
        bit_time(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        bit_time(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        cur_test = "zeros";
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);

        // Ten 1s -> 11111 0 11111 0.
        do_reset();
        cur_test = "ones";
        for (int i = 1; i <= 5; i++) begin
            bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'(i));
        end
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        for (int i = 1; i <= 5; i++) begin
            bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'(i));
        end
        bit_time(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);

        // Five 0s, stuff_en drops on the stuff tick; six 0s unstuffed follow.
        do_reset();
        cur_test = "crc_end";
        for (int i = 1; i <= 5; i++) begin
            bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
        end
        bit_time(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
        for (int i = 0; i < 6; i++) begin
            bit_time(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        end

        // Underrun in DATA: line goes recessive, flag sticks.
        do_reset();
        cur_test = "underrun";
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
        check_val("ur_before", 8'(underrun), 8'd0);
        bit_time(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        check_val("ur_set", 8'(underrun), 8'd1);
        bit_time(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
        check_val("ur_sticky", 8'(underrun), 8'd1);

        // Reset while a stuff bit is owed: no stuff bit after release.
        do_reset();
        cur_test = "rst_stuff";
        for (int i = 1; i <= 5; i++) begin
            bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_val("async_tx", 8'(tx), 8'd1);
        check_val("async_rc", 8'(run_cnt), 8'd0);
        @(negedge clock);
        reset = 1'b0;
        sb_q.delete();
        bit_time(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        check_val("idle_ur", 8'(underrun), 8'd0);
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);

`ifdef CAN_TX_STUFF_ERR_INJ_EN
        // Injected stuff error: wrong-polarity stuff bit, run stays saturated.
        do_reset();
        cur_test = "inject";
        for (int i = 1; i <= 5; i++) begin
            bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'(i));
        end
        inject_stuff_err = 1'b1;
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5);
        inject_stuff_err = 1'b0;
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5);
        bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5);
        bit_time(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
